cv32e40p_tmr_fault_mgr: RTL

- Consumes the per-replica mismatch flags produced by the voters of the triplicated ALU.
- Keeps per-replica error counters and declares a replica faulted once its counter reaches a threshold.
- Drives the one-hot spare-select that steers the spare replica into the faulted slot's voter input.
- Escalates to a sticky fatal state when faults can no longer be masked.

---
 rtl/cv32e40p_tmr_fault_mgr.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cv32e40p_tmr_fault_mgr.sv
// ============================================================================
// cv32e40p_tmr_fault_mgr
//
// Fault manager for the triplicated ALU. Collects the per-replica mismatch
// flags reported by the voters and keeps one saturating error counter per
// replica slot. When a slot's counter reaches THRESHOLD it is declared
// faulted, and the spare replica is steered into that slot through a one-hot
// spare select. The manager escalates to a sticky FATAL state once masking
// can no longer be guaranteed, for example a second trip, a failed spare, or
// two slots flagged in the same sample. Every output is registered.
//
// Optional feature (compile-time macro CV32E40P_TMR_LEAKY_EN):
//   When defined, a clean-sample timer leaks the counters. Every DECAY_PERIOD
//   samples without any hit, each nonzero counter decrements by one. When the
//   macro is undefined the counters only ever increment.
//
// Ports:
//   clk          in   core clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   sample_i     in   voter flags are valid this cycle
//   err_a_i      in   [NVOTER] mismatch flags for replica slot 0
//   err_b_i      in   [NVOTER] mismatch flags for replica slot 1
//   err_c_i      in   [NVOTER] mismatch flags for replica slot 2
//   clr_i        in   software clear, with the same effect as reset
//   spare_sel_o  out  [3] one-hot slot occupied by the spare (0 = none)
//   faulted_o    out  [3] sticky per-slot faulted flags
//   fatal_o      out  sticky, masking is no longer guaranteed
//   uncorr_o     out  one-cycle pulse after a sample with two or more hits
//   state_o      out  [2] 0 NORMAL, 1 SPARED, 2 FATAL
// ============================================================================
module cv32e40p_tmr_fault_mgr #(
    parameter int unsigned NVOTER       = 3,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned THRESHOLD    = 4,
    parameter int unsigned DECAY_PERIOD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_i,
    input  logic [NVOTER-1:0] err_a_i,
    input  logic [NVOTER-1:0] err_b_i,
    input  logic [NVOTER-1:0] err_c_i,
    input  logic              clr_i,
    output logic [2:0]        spare_sel_o,
    output logic [2:0]        faulted_o,
    output logic              fatal_o,
    output logic              uncorr_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        SPARED = 2'd1,
        FATAL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TH_VAL  = CNT_W'(THRESHOLD);

    state_t                  state;
    logic [2:0][CNT_W-1:0]   cnt;
    logic [2:0][CNT_W-1:0]   cnt_inc;
    logic [2:0][CNT_W-1:0]   cnt_next;
    logic [2:0][CNT_W-1:0]   cnt_load;
    logic [2:0]              hit;
    logic [2:0]              trip;
    logic                    multi_hit;
    logic                    single_trip;
    logic                    take_spare;

    // A slot is hit when any voter blames it during a valid sample.
    always_comb begin
        hit[0] = sample_i & (|err_a_i);
        hit[1] = sample_i & (|err_b_i);
        hit[2] = sample_i & (|err_c_i);
        multi_hit = (hit[0] & hit[1]) | (hit[0] & hit[2]) | (hit[1] & hit[2]);
    end

`ifdef CV32E40P_TMR_LEAKY_EN
    // The timer runs 0..DECAY_PERIOD-1. The clean sample that would reach
    // DECAY_PERIOD wraps the timer to 0 and triggers one decay step instead.
    localparam int unsigned TMR_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_next;
    logic             decay;

    always_comb begin
        decay      = 1'b0;
        timer_next = timer;
        if (hit != '0) begin
            timer_next = '0;
        end else if (sample_i) begin
            if (timer == TMR_W'(DECAY_PERIOD - 1)) begin
                decay      = 1'b1;
                timer_next = '0;
            end else begin
                timer_next = timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            timer <= '0;
        end else begin
            timer <= timer_next;
        end
    end
`endif

    // Counter next values and trip detection. Decay only happens on a sample
    // with no hits at all, so it never coincides with an increment.
    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            cnt_inc[k]  = (cnt[k] == CNT_MAX) ? cnt[k] : cnt[k] + 1'b1;
            trip[k]     = hit[k] && (cnt_inc[k] == TH_VAL);
            cnt_next[k] = hit[k] ? cnt_inc[k] : cnt[k];
`ifdef CV32E40P_TMR_LEAKY_EN
            if (decay && (cnt[k] != '0)) begin
                cnt_next[k] = cnt[k] - 1'b1;
            end
`endif
        end
    end

    // The spare is only taken for a lone trip in NORMAL without a
    // simultaneous multi-slot hit. The slot's counter restarts at 0 so that
    // it tracks the spare from then on.
    always_comb begin
        single_trip = (trip != '0) && ((trip & (trip - 3'd1)) == '0);
        take_spare  = (state == NORMAL) && !multi_hit && single_trip;
        for (int unsigned k = 0; k < 3; k++) begin
            cnt_load[k] = (take_spare && trip[k]) ? '0 : cnt_next[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            state       <= NORMAL;
            cnt         <= '0;
            spare_sel_o <= '0;
            faulted_o   <= '0;
            fatal_o     <= 1'b0;
            uncorr_o    <= 1'b0;
        end else begin
            cnt       <= cnt_load;
            faulted_o <= faulted_o | trip;
            uncorr_o  <= multi_hit;
            unique case (state)
                NORMAL: begin
                    if (take_spare) begin
                        state       <= SPARED;
                        spare_sel_o <= trip;
                    end else if (multi_hit || (trip != '0)) begin
                        state   <= FATAL;
                        fatal_o <= 1'b1;
                    end
                end
                SPARED: begin
                    // Any further trip, including the spare itself, is unmaskable.
                    if (multi_hit || (trip != '0)) begin
                        state   <= FATAL;
                        fatal_o <= 1'b1;
                    end
                end
                FATAL: begin
                    state <= FATAL;
                end
                default: begin
                    state   <= FATAL;
                    fatal_o <= 1'b1;
                end
            endcase
        end
    end

    always_comb state_o = state;

endmodule
